// File: rtl/mips_run_ctrl.sv
// Run controller for a pipelined MIPS core: sequences CPU reset, enables execution,
// and stops the run on halt, PC stall or cycle budget while counting cycles and retirements.
module mips_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned MAX_CYCLES   = 350,
  parameter int unsigned STALL_LIMIT  = 16,
  parameter logic [31:0] HALT_PC      = 32'hFFFF_FFFC,
  parameter bit          HALT_PC_EN   = 1'b1,
  parameter bit          AUTO_START   = 1'b1,
  parameter int unsigned CW           = 32
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          halt_in,
  input  logic [31:0]   pc_in,
  input  logic          retire_valid,
  output logic          cpu_res,
  output logic          run,
  output logic          done,
  output logic [1:0]    stop_cause,
  output logic [CW-1:0] cycle_cnt,
  output logic [CW-1:0] instr_cnt
);

  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [7:0]    RST_LAST   = 8'(RESET_CYCLES - 1);
  localparam logic [63:0]   TIME_LAST  = 64'(MAX_CYCLES) - 64'd1;
  localparam logic [31:0]   STALL_LAST = 32'(STALL_LIMIT) - 32'd1;

  state_t        state, state_n;
  logic [7:0]    rst_cnt, rst_cnt_n;
  logic [31:0]   stall_cnt, stall_cnt_n;
  logic [31:0]   prev_pc;
  logic          pc_valid, pc_valid_n;
  logic          cpu_res_n, run_n, done_n;
  logic [1:0]    cause_n;
  logic [CW-1:0] cyc_n, ins_n;
  logic          pc_same, halt_hit, stall_hit, time_hit;

  // pc_valid keeps the first RUN cycle from comparing against a PC seen while the CPU was held in reset.
  always_comb begin
    pc_same   = pc_valid && (pc_in == prev_pc);
    halt_hit  = halt_in || (HALT_PC_EN && (pc_in == HALT_PC));
    stall_hit = (STALL_LIMIT != 0) && pc_same && (stall_cnt == STALL_LAST);
    time_hit  = (MAX_CYCLES != 0) && (64'(cycle_cnt) == TIME_LAST);
  end

  always_comb begin
    state_n     = state;
    rst_cnt_n   = rst_cnt;
    stall_cnt_n = stall_cnt;
    pc_valid_n  = pc_valid;
    cause_n     = stop_cause;
    cyc_n       = cycle_cnt;
    ins_n       = instr_cnt;
    case (state)
      IDLE: if (start || AUTO_START) state_n = RST;
      RST: begin
        if (rst_cnt == RST_LAST) state_n = RUN;
        else rst_cnt_n = rst_cnt + 8'd1;
      end
      RUN: begin
        if (cycle_cnt != CNT_MAX) cyc_n = cycle_cnt + CW'(1);
        if (retire_valid && (instr_cnt != CNT_MAX)) ins_n = instr_cnt + CW'(1);
        pc_valid_n = 1'b1;
        if (!pc_same) stall_cnt_n = '0;
        else if (stall_cnt != 32'hFFFF_FFFF) stall_cnt_n = stall_cnt + 32'd1;
        if (halt_hit) begin
          state_n = DONE;
          cause_n = 2'd1;
        end else if (stall_hit) begin
          state_n = DONE;
          cause_n = 2'd3;
        end else if (time_hit) begin
          state_n = DONE;
          cause_n = 2'd2;
        end
      end
      DONE: if (start) state_n = RST;
      default: state_n = IDLE;
    endcase
    // Every fresh entry into RST starts a clean run.
    if ((state_n == RST) && (state != RST)) begin
      rst_cnt_n   = '0;
      stall_cnt_n = '0;
      pc_valid_n  = 1'b0;
      cause_n     = 2'd0;
      cyc_n       = '0;
      ins_n       = '0;
    end
    cpu_res_n = (state_n == IDLE) || (state_n == RST);
    run_n     = (state_n == RUN);
    done_n    = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      stall_cnt  <= '0;
      pc_valid   <= 1'b0;
      prev_pc    <= '0;
      cpu_res    <= 1'b1;
      run        <= 1'b0;
      done       <= 1'b0;
      stop_cause <= 2'd0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
    end else begin
      state      <= state_n;
      rst_cnt    <= rst_cnt_n;
      stall_cnt  <= stall_cnt_n;
      pc_valid   <= pc_valid_n;
      prev_pc    <= pc_in;
      cpu_res    <= cpu_res_n;
      run        <= run_n;
      done       <= done_n;
      stop_cause <= cause_n;
      cycle_cnt  <= cyc_n;
      instr_cnt  <= ins_n;
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Testbench for mips_run_ctrl: four parameterizations share one stimulus bus; each scenario
// checks one instance against expectations derived from the run-control rules.
module tb_mips_run_ctrl;

  logic clk = 1'b0;
  logic res, start, halt_in, retire_valid;
  logic [31:0] pc_in;

  always #5 clk = ~clk;

  logic a_cpu_res, a_run, a_done; logic [1:0] a_cause; logic [31:0] a_cyc, a_ins;
  logic b_cpu_res, b_run, b_done; logic [1:0] b_cause; logic [31:0] b_cyc, b_ins;
  logic c_cpu_res, c_run, c_done; logic [1:0] c_cause; logic [31:0] c_cyc, c_ins;
  logic d_cpu_res, d_run, d_done; logic [1:0] d_cause; logic [3:0]  d_cyc, d_ins;

  mips_run_ctrl u_a (
    .clk(clk), .res(res), .start(start), .halt_in(halt_in), .pc_in(pc_in),
    .retire_valid(retire_valid), .cpu_res(a_cpu_res), .run(a_run), .done(a_done),
    .stop_cause(a_cause), .cycle_cnt(a_cyc), .instr_cnt(a_ins));

  mips_run_ctrl #(.RESET_CYCLES(4), .MAX_CYCLES(30), .STALL_LIMIT(3), .AUTO_START(1'b0)) u_b (
    .clk(clk), .res(res), .start(start), .halt_in(halt_in), .pc_in(pc_in),
    .retire_valid(retire_valid), .cpu_res(b_cpu_res), .run(b_run), .done(b_done),
    .stop_cause(b_cause), .cycle_cnt(b_cyc), .instr_cnt(b_ins));

  mips_run_ctrl #(.MAX_CYCLES(8), .STALL_LIMIT(0)) u_c (
    .clk(clk), .res(res), .start(start), .halt_in(halt_in), .pc_in(pc_in),
    .retire_valid(retire_valid), .cpu_res(c_cpu_res), .run(c_run), .done(c_done),
    .stop_cause(c_cause), .cycle_cnt(c_cyc), .instr_cnt(c_ins));

  mips_run_ctrl #(.CW(4), .MAX_CYCLES(0), .STALL_LIMIT(0)) u_d (
    .clk(clk), .res(res), .start(start), .halt_in(halt_in), .pc_in(pc_in),
    .retire_valid(retire_valid), .cpu_res(d_cpu_res), .run(d_run), .done(d_done),
    .stop_cause(d_cause), .cycle_cnt(d_cyc), .instr_cnt(d_ins));

  int total = 0;
  int bad = 0;

  // Per-RUN-cycle stimulus, indexed by RUN cycle number starting at 1.
  logic        st_halt [1:400];
  logic [31:0] st_pc   [1:400];
  logic        st_ret  [1:400];

  int rst_hi, run_cyc;
  bit timed_out;

  function automatic logic run_of(input int sel);
    case (sel)
      0: return a_run;
      1: return b_run;
      2: return c_run;
      default: return d_run;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0: return a_done;
      1: return b_done;
      2: return c_done;
      default: return d_done;
    endcase
  endfunction

  function automatic logic cpures_of(input int sel);
    case (sel)
      0: return a_cpu_res;
      1: return b_cpu_res;
      2: return c_cpu_res;
      default: return d_cpu_res;
    endcase
  endfunction

  task automatic clear_stim();
    for (int k = 1; k <= 400; k++) begin
      st_halt[k] = 1'b0;
      st_pc[k]   = 32'h1000 + 32'(4 * k);
      st_ret[k]  = 1'b0;
    end
  endtask

  // Reset everything, launch a run, feed the stimulus tables while the chosen instance runs.
  task automatic run_program(input int sel, input bit use_start, input int budget);
    res = 1'b1; start = 1'b0; halt_in = 1'b0; retire_valid = 1'b0; pc_in = '0;
    @(negedge clk);
    res = 1'b0; start = use_start;
    @(negedge clk);
    start = 1'b0;
    rst_hi = 0; run_cyc = 0; timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (run_of(sel)) begin
        run_cyc++;
        if (run_cyc <= 400) begin
          halt_in = st_halt[run_cyc]; pc_in = st_pc[run_cyc]; retire_valid = st_ret[run_cyc];
        end else begin
          halt_in = 1'b0; pc_in = 32'h0800_0000 + 32'(4 * run_cyc); retire_valid = 1'b0;
        end
      end else if (done_of(sel)) begin
        timed_out = 1'b0;
        break;
      end else begin
        if (cpures_of(sel)) rst_hi++;
        halt_in = 1'b0; pc_in = '0; retire_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    halt_in = 1'b0; retire_valid = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1; start = 1'b1; halt_in = 1'b1; retire_valid = 1'b1; pc_in = 32'h40;
    @(negedge clk);
    @(negedge clk);
    total++; if (a_cpu_res !== 1'b1) begin bad++; $display("[TB] FAIL reset_cpu_res: got %0d want 1", a_cpu_res); end
    total++; if (a_run !== 1'b0) begin bad++; $display("[TB] FAIL reset_run: got %0d want 0", a_run); end
    total++; if (a_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %0d want 0", a_done); end
    total++; if (a_cause !== 2'd0) begin bad++; $display("[TB] FAIL reset_cause: got %0d want 0", a_cause); end
    total++; if (a_cyc !== 32'd0 || a_ins !== 32'd0) begin bad++; $display("[TB] FAIL reset_counts: got %0d/%0d want 0/0", a_cyc, a_ins); end
    total++; if (b_cpu_res !== 1'b1 || d_cyc !== 4'd0) begin bad++; $display("[TB] FAIL reset_other: got %0d/%0d want 1/0", b_cpu_res, d_cyc); end
    start = 1'b0; halt_in = 1'b0; retire_valid = 1'b0;
  endtask

  task automatic test_timeout();
    clear_stim();
    run_program(0, 1'b0, 400);
    total++; if (timed_out) begin bad++; $display("[TB] FAIL timeout_wait: got no done want done"); end
    total++; if (rst_hi != 1) begin bad++; $display("[TB] FAIL timeout_rst_len: got %0d want 1", rst_hi); end
    total++; if (run_cyc != 350) begin bad++; $display("[TB] FAIL timeout_run_len: got %0d want 350", run_cyc); end
    total++; if (a_cause !== 2'd2) begin bad++; $display("[TB] FAIL timeout_cause: got %0d want 2", a_cause); end
    total++; if (a_cyc !== 32'd350) begin bad++; $display("[TB] FAIL timeout_cycles: got %0d want 350", a_cyc); end
    total++; if (a_ins !== 32'd0) begin bad++; $display("[TB] FAIL timeout_instr: got %0d want 0", a_ins); end
    total++; if (a_done !== 1'b1 || a_run !== 1'b0 || a_cpu_res !== 1'b0) begin bad++; $display("[TB] FAIL timeout_flags: got %0d%0d%0d want 100", a_done, a_run, a_cpu_res); end
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 5; i++) begin
      retire_valid = 1'b1; halt_in = 1'b1; pc_in = 32'h40 + 32'(4 * i);
      @(negedge clk);
    end
    retire_valid = 1'b0; halt_in = 1'b0;
    total++; if (a_done !== 1'b1 || a_run !== 1'b0) begin bad++; $display("[TB] FAIL hold_flags: got %0d%0d want 10", a_done, a_run); end
    total++; if (a_cyc !== 32'd350 || a_ins !== 32'd0 || a_cause !== 2'd2) begin bad++; $display("[TB] FAIL hold_values: got %0d/%0d/%0d want 350/0/2", a_cyc, a_ins, a_cause); end
  endtask

  task automatic test_halt();
    clear_stim();
    for (int k = 1; k <= 400; k++) st_ret[k] = 1'b1;
    st_halt[10] = 1'b1;
    run_program(1, 1'b1, 100);
    total++; if (timed_out) begin bad++; $display("[TB] FAIL halt_wait: got no done want done"); end
    total++; if (rst_hi != 4) begin bad++; $display("[TB] FAIL halt_rst_len: got %0d want 4", rst_hi); end
    total++; if (b_cause !== 2'd1) begin bad++; $display("[TB] FAIL halt_cause: got %0d want 1", b_cause); end
    total++; if (b_cyc !== 32'd10 || b_ins !== 32'd10) begin bad++; $display("[TB] FAIL halt_counts: got %0d/%0d want 10/10", b_cyc, b_ins); end
  endtask

  // Start while DONE re-runs with cleared counters; start held during RST and RUN must be ignored.
  task automatic test_rerun();
    int k, hi;
    bit seen;
    clear_stim();
    st_halt[3] = 1'b1;
    start = 1'b1;
    @(negedge clk);
    total++; if (b_cpu_res !== 1'b1 || b_done !== 1'b0) begin bad++; $display("[TB] FAIL rerun_enter: got %0d%0d want 10", b_cpu_res, b_done); end
    total++; if (b_cyc !== 32'd0 || b_ins !== 32'd0 || b_cause !== 2'd0) begin bad++; $display("[TB] FAIL rerun_clear: got %0d/%0d/%0d want 0/0/0", b_cyc, b_ins, b_cause); end
    k = 0; hi = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (b_run) begin
        k++; halt_in = st_halt[k]; retire_valid = 1'b1; pc_in = st_pc[k]; start = 1'b1;
      end else if (b_done) begin
        seen = 1'b1;
        break;
      end else begin
        if (b_cpu_res) hi++;
        start = 1'b1; retire_valid = 1'b1; pc_in = '0;
      end
      @(negedge clk);
    end
    start = 1'b0; halt_in = 1'b0; retire_valid = 1'b0;
    total++; if (!seen) begin bad++; $display("[TB] FAIL rerun_wait: got no done want done"); end
    total++; if (hi != 4) begin bad++; $display("[TB] FAIL rerun_rst_len: got %0d want 4", hi); end
    total++; if (b_cause !== 2'd1 || b_cyc !== 32'd3 || b_ins !== 32'd3) begin bad++; $display("[TB] FAIL rerun_result: got %0d/%0d/%0d want 1/3/3", b_cause, b_cyc, b_ins); end
  endtask

  task automatic test_stall();
    int eins;
    clear_stim();
    eins = 0;
    for (int k = 1; k <= 400; k++) begin
      if (k >= 5) st_pc[k] = 32'h40;
      st_ret[k] = 1'($urandom_range(0, 1));
      if (k <= 8 && st_ret[k]) eins++;
    end
    run_program(1, 1'b1, 100);
    total++; if (timed_out) begin bad++; $display("[TB] FAIL stall_wait: got no done want done"); end
    total++; if (b_cause !== 2'd3) begin bad++; $display("[TB] FAIL stall_cause: got %0d want 3", b_cause); end
    total++; if (b_cyc !== 32'd8 || run_cyc != 8) begin bad++; $display("[TB] FAIL stall_cycles: got %0d/%0d want 8/8", b_cyc, run_cyc); end
    total++; if (b_ins !== 32'(eins)) begin bad++; $display("[TB] FAIL stall_instr: got %0d want %0d", b_ins, eins); end
  endtask

  task automatic test_priority();
    clear_stim();
    for (int k = 27; k <= 400; k++) st_pc[k] = 32'h500;
    run_program(1, 1'b1, 100);
    total++; if (b_cause !== 2'd3 || b_cyc !== 32'd30) begin bad++; $display("[TB] FAIL prio_stall_vs_time: got %0d/%0d want 3/30", b_cause, b_cyc); end
    st_halt[30] = 1'b1;
    run_program(1, 1'b1, 100);
    total++; if (b_cause !== 2'd1 || b_cyc !== 32'd30) begin bad++; $display("[TB] FAIL prio_halt_vs_stall: got %0d/%0d want 1/30", b_cause, b_cyc); end
  endtask

  task automatic test_halt_vs_timeout();
    clear_stim();
    st_halt[8] = 1'b1;
    run_program(2, 1'b0, 50);
    total++; if (c_cause !== 2'd1 || c_cyc !== 32'd8 || run_cyc != 8) begin bad++; $display("[TB] FAIL halt_vs_time: got %0d/%0d/%0d want 1/8/8", c_cause, c_cyc, run_cyc); end
    clear_stim();
    run_program(2, 1'b0, 50);
    total++; if (c_cause !== 2'd2 || c_cyc !== 32'd8) begin bad++; $display("[TB] FAIL short_timeout: got %0d/%0d want 2/8", c_cause, c_cyc); end
    st_pc[5] = 32'hFFFF_FFFC;
    run_program(2, 1'b0, 50);
    total++; if (c_cause !== 2'd1 || c_cyc !== 32'd5) begin bad++; $display("[TB] FAIL halt_pc: got %0d/%0d want 1/5", c_cause, c_cyc); end
  endtask

  task automatic test_res_mid_run();
    int n;
    bit found;
    res = 1'b1; start = 1'b0; halt_in = 1'b0; retire_valid = 1'b0; pc_in = '0;
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    n = 0; found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (a_run) begin
        n++;
        if (n == 20) begin found = 1'b1; break; end
      end
      retire_valid = 1'b1; pc_in = 32'h2000 + 32'(4 * i);
      @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL midrun_wait: got %0d run cycles want 20", n); end
    total++; if (a_cyc !== 32'd19 || a_ins !== 32'd19) begin bad++; $display("[TB] FAIL midrun_counts: got %0d/%0d want 19/19", a_cyc, a_ins); end
    res = 1'b1; start = 1'b1; halt_in = 1'b1; retire_valid = 1'b1;
    @(negedge clk);
    total++; if (a_cpu_res !== 1'b1 || a_run !== 1'b0 || a_done !== 1'b0) begin bad++; $display("[TB] FAIL midrun_abort: got %0d%0d%0d want 100", a_cpu_res, a_run, a_done); end
    total++; if (a_cyc !== 32'd0 || a_ins !== 32'd0 || a_cause !== 2'd0) begin bad++; $display("[TB] FAIL midrun_clear: got %0d/%0d/%0d want 0/0/0", a_cyc, a_ins, a_cause); end
    start = 1'b0; halt_in = 1'b0; retire_valid = 1'b0;
  endtask

  task automatic test_saturate();
    bit found;
    res = 1'b1; start = 1'b0; halt_in = 1'b0; retire_valid = 1'b0; pc_in = '0;
    @(negedge clk);
    res = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d_run) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL sat_wait: got no run want run"); end
    for (int k = 1; k <= 25; k++) begin
      if (k == 15) begin
        total++; if (d_cyc !== 4'd14) begin bad++; $display("[TB] FAIL sat_mid: got %0d want 14", d_cyc); end
      end
      retire_valid = 1'b1; pc_in = 32'h3000 + 32'(4 * k);
      @(negedge clk);
    end
    retire_valid = 1'b0;
    total++; if (d_cyc !== 4'd15 || d_ins !== 4'd15) begin bad++; $display("[TB] FAIL sat_counts: got %0d/%0d want 15/15", d_cyc, d_ins); end
    total++; if (d_run !== 1'b1 || d_done !== 1'b0 || d_cause !== 2'd0) begin bad++; $display("[TB] FAIL sat_running: got %0d%0d/%0d want 10/0", d_run, d_done, d_cause); end
  endtask

  // Reference: scan the RUN-cycle tables for the first cycle meeting halt, then stall, then timeout.
  task automatic test_random_runs();
    for (int it = 0; it < 14; it++) begin
      int ecause, ecyc, eins, reps, rep_pct;
      clear_stim();
      rep_pct = (it % 2 == 0) ? 12 : 45;
      for (int k = 1; k <= 40; k++) begin
        st_halt[k] = ($urandom_range(0, 99) < 4);
        st_ret[k]  = 1'($urandom_range(0, 1));
        if (k > 1 && $urandom_range(0, 99) < rep_pct) st_pc[k] = st_pc[k-1];
        else if ($urandom_range(0, 99) < 2) st_pc[k] = 32'hFFFF_FFFC;
        else st_pc[k] = 32'h100 + 32'(4 * $urandom_range(0, 7));
      end
      ecause = 0; ecyc = 0; eins = 0; reps = 0;
      for (int k = 1; k <= 40 && ecause == 0; k++) begin
        ecyc = k;
        if (st_ret[k]) eins++;
        reps = (k > 1 && st_pc[k] == st_pc[k-1]) ? reps + 1 : 0;
        if (st_halt[k] || st_pc[k] == 32'hFFFF_FFFC) ecause = 1;
        else if (reps >= 3) ecause = 3;
        else if (k == 30) ecause = 2;
      end
      run_program(1, 1'b1, 80);
      total++; if (timed_out || b_done !== 1'b1) begin bad++; $display("[TB] FAIL rand%0d_done: got %0d want 1", it, b_done); end
      total++; if (b_cause !== 2'(ecause)) begin bad++; $display("[TB] FAIL rand%0d_cause: got %0d want %0d", it, b_cause, ecause); end
      total++; if (b_cyc !== 32'(ecyc) || run_cyc != ecyc) begin bad++; $display("[TB] FAIL rand%0d_cycles: got %0d/%0d want %0d", it, b_cyc, run_cyc, ecyc); end
      total++; if (b_ins !== 32'(eins)) begin bad++; $display("[TB] FAIL rand%0d_instr: got %0d want %0d", it, b_ins, eins); end
    end
  endtask

  initial begin
    res = 1'b1; start = 1'b0; halt_in = 1'b0; retire_valid = 1'b0; pc_in = '0;
    test_reset();
    test_timeout();
    test_done_hold();
    test_halt();
    test_rerun();
    test_stall();
    test_priority();
    test_halt_vs_timeout();
    test_res_mid_run();
    test_saturate();
    test_random_runs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 1: CPU reset hold length, in clk cycles; legal range 1..255.
REQ-002 Parameter MAX_CYCLES, default 350: RUN-cycle budget; 0 disables timeout.
REQ-003 Parameter STALL_LIMIT, default 16: consecutive unchanged-PC cycles that count as a stall halt; 0 disables.
REQ-004 Parameter HALT_PC, default 32'hFFFF_FFFC: PC value that signals program end.
REQ-005 Parameter HALT_PC_EN, default 1: enables the HALT_PC match.
REQ-006 Parameter AUTO_START, default 1: begin a run automatically after res releases.
REQ-007 Parameter CW, default 32: width of both counters.
REQ-008 clk  in  1  sole clock; all state updates on rising edge.
REQ-009 res  in  1  reset; synchronous, active-high.
REQ-010 start  in  1  single-cycle request to begin or re-run a program.
REQ-011 halt_in  in  1  explicit halt from the CPU.
REQ-012 pc_in  in  32  current CPU fetch PC.
REQ-013 retire_valid  in  1  one instruction retired this cycle.
REQ-014 cpu_res  out  1  registered reset driven to the pipelined CPU.
REQ-015 run  out  1  CPU enable; high only in RUN.
REQ-016 done  out  1  run finished; sticky until the next run or res.
REQ-017 stop_cause  out  2  0 none, 1 halt, 2 timeout, 3 stall.
REQ-018 cycle_cnt  out  CW  completed RUN cycles.
REQ-019 instr_cnt  out  CW  retired instructions during RUN.

Function
REQ-020 The FSM SHALL have states IDLE, RST, RUN and DONE; all outputs registered.
REQ-021 IDLE: cpu_res=1, run=0; the FSM SHALL move to RST on start=1, or on the first cycle after res releases if AUTO_START=1.
REQ-022 Entering RST SHALL clear cycle_cnt, instr_cnt, stop_cause, done and the stall counter.
REQ-023 RST: cpu_res=1 for exactly RESET_CYCLES cycles, then RUN.
REQ-024 RUN: cpu_res=0, run=1; cycle_cnt SHALL increment by 1 every RUN cycle.
REQ-025 RUN: instr_cnt SHALL increment when retire_valid=1; retire_valid outside RUN SHALL be ignored.
REQ-026 Both counters SHALL saturate at all-ones and never wrap.
REQ-027 Halt: halt_in=1, or HALT_PC_EN=1 with pc_in==HALT_PC, in a RUN cycle SHALL move the FSM to DONE with stop_cause=1.
REQ-028 Stall tracking: the previous pc_in is registered; the stall counter increments when pc_in equals it and clears otherwise.
REQ-029 Stall halt: when the stall counter reaches STALL_LIMIT (nonzero), the FSM SHALL move to DONE with stop_cause=3.
REQ-030 Timeout: the RUN cycle in which cycle_cnt==MAX_CYCLES-1 (MAX_CYCLES nonzero) SHALL be the last; DONE follows with cycle_cnt=MAX_CYCLES and stop_cause=2.
REQ-031 When causes coincide in one cycle, priority SHALL be halt > stall > timeout.
REQ-032 The terminating RUN cycle SHALL still be counted, including any retire_valid in it.
REQ-033 DONE: run=0, cpu_res=0, done=1; counters and stop_cause hold.
REQ-034 start in DONE SHALL re-enter RST; start in RST or RUN SHALL be ignored.
REQ-035 A RUN or RST with no cause and MAX_CYCLES=0 and STALL_LIMIT=0 SHALL run indefinitely with saturating counters.

Reset
REQ-036 res=1 SHALL, on the same edge, force state IDLE, cpu_res=1, run=0, done=0, stop_cause=0, cycle_cnt=0, instr_cnt=0, stall counter 0.
REQ-037 res asserted mid-RST, mid-RUN or in DONE SHALL abort immediately to the reset values, regardless of start.
REQ-038 res has priority over every other input.

Verification
REQ-039 Defaults, res high 1 cycle then low, halt_in and retire_valid held 0, pc_in incrementing by 4 -> cpu_res high 1 cycle after release, run for 350 cycles, done=1, stop_cause=2, cycle_cnt=350, instr_cnt=0.
REQ-040 RESET_CYCLES=4, halt_in pulsed in the 10th RUN cycle, retire_valid every cycle -> cpu_res high 4 cycles, DONE with stop_cause=1, cycle_cnt=10, instr_cnt=10.
REQ-041 STALL_LIMIT=3, pc_in frozen at 0x40 from RUN cycle 5 -> stop_cause=3 on the 3rd repeated-PC cycle; cycle_cnt matches that cycle.
REQ-042 halt_in and timeout in the same cycle (MAX_CYCLES=8, halt_in in RUN cycle 8) -> stop_cause=1, cycle_cnt=8.
REQ-043 res asserted in RUN cycle 20 -> next cycle IDLE, all counters 0, cpu_res=1; with AUTO_START=0, start pulse in DONE -> new run with cleared counters.
REQ-044 CW=4, MAX_CYCLES=0, STALL_LIMIT=0 -> cycle_cnt saturates at 15, run stays 1.
